// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder front-end: streams one nibble per clock through an external 4-bit ripple_carry.
// Optional signed-overflow flag output enabled by defining NSA_OVF_EN.
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic [3:0]           rca_x,
   output logic [3:0]           rca_y,
   output logic                 rca_z,
   input  logic [3:0]           rca_sum,
   input  logic                 rca_carry,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] result,
   output logic                 cout,
`ifdef NSA_OVF_EN
   output logic                 ovf,
`endif
   output logic                 busy
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [W-1:0]     a_q, b_q;
   logic             carry_q;
   logic             accept, last;

   assign accept = (state == IDLE) && in_valid;
   assign last   = (state == RUN) && (idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            result  <= '0;
         end else if (state == RUN) begin
            result[{idx, 2'b00} +: 4] <= rca_sum;
            carry_q                   <= rca_carry;
            idx                       <= last ? '0 : idx + 1'b1;
            if (last)
               cout <= rca_carry;
         end
      end
   end

`ifdef NSA_OVF_EN
   // Signed overflow: operands agree in sign but the top nibble's sum bit disagrees.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (accept)
         ovf <= 1'b0;
      else if (last)
         ovf <= (a_q[W-1] == b_q[W-1]) && (rca_sum[3] != a_q[W-1]);
   end
`endif

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      rca_x     = 4'd0;
      rca_y     = 4'd0;
      rca_z     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = RUN;
         end
         RUN: begin
            busy  = 1'b1;
            rca_x = a_q[{idx, 2'b00} +: 4];
            rca_y = b_q[{idx, 2'b00} +: 4];
            rca_z = carry_q;
            if (idx == IDX_LAST)
               state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
